// File: rtl/st_msg_pkt_serializer.sv
// Message-to-packet serialiser: latches a whole message, emits sop/eop-framed WIDTH-bit beats.
// Optional saturating drop/clamp error counter enabled by macro ST_SER_ERR_CNT_EN.
module st_msg_pkt_serializer #(
    parameter  int WIDTH     = 32,
    parameter  int MAX_BYTES = 16,
    parameter  int CNT_W     = 8,
    localparam int BPB       = WIDTH / 8,
    localparam int NB_W      = $clog2(MAX_BYTES + 1),
    localparam int LEN_W     = $clog2(BPB)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_msg_valid,
    output logic                   i_msg_ready,
    input  logic [MAX_BYTES*8-1:0] i_msg_data,
    input  logic [NB_W-1:0]        i_msg_nbytes,
    output logic                   o_pkt_valid,
    input  logic                   o_pkt_ready,
    output logic                   o_pkt_sop,
    output logic                   o_pkt_eop,
    output logic [WIDTH-1:0]       o_pkt_data,
    output logic [LEN_W-1:0]       o_pkt_len,
    output logic                   o_busy
`ifdef ST_SER_ERR_CNT_EN
    ,output logic [CNT_W-1:0]      o_err_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_ready, r_valid, r_sop, r_eop, r_busy;
    logic [WIDTH-1:0]       r_pkt_data;
    logic [LEN_W-1:0]       r_len;
    logic [MAX_BYTES*8-1:0] r_data;
    logic [NB_W-1:0]        r_n, r_last, r_cnt;

    logic                   w_accept, w_load, w_fire, w_beat_eop;
    logic [NB_W-1:0]        w_n, w_last, w_idx, w_nsel, w_lastsel;
    logic [MAX_BYTES*8-1:0] w_src;
    logic [WIDTH-1:0]       w_beat;
    logic [LEN_W-1:0]       w_beat_len;

    // Byte idx*BPB+j goes to lane j counted from the MS end; lanes past n read as zero.
    function automatic logic [WIDTH-1:0] f_beat(input logic [MAX_BYTES*8-1:0] src,
                                                 input logic [NB_W-1:0] idx,
                                                 input logic [NB_W-1:0] n);
        logic [WIDTH-1:0] v;
        int               b;
        v = '0;
        for (int j = 0; j < BPB; j++) begin
            b = int'(idx) * BPB + j;
            if (b < int'(n) && b < MAX_BYTES) begin
                v[WIDTH-1-8*j -: 8] = src[8*b +: 8];
            end else begin
                v[WIDTH-1-8*j -: 8] = 8'h00;
            end
        end
        return v;
    endfunction

    assign w_accept = i_msg_valid & r_ready;
    assign w_n      = (i_msg_nbytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : i_msg_nbytes;
    assign w_last   = NB_W'((int'(w_n) + BPB - 1) / BPB - 1);
    assign w_load   = w_accept & (w_n != '0);
    assign w_fire   = r_valid & o_pkt_ready;

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_load) w_state_nxt = SEND;
                else        w_state_nxt = IDLE;
            end
            SEND: begin
                if (w_fire && r_eop) w_state_nxt = IDLE;
                else                 w_state_nxt = SEND;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next beat: beat 0 straight from the input on accept, else the following latched beat.
    always_comb begin
        w_src     = r_data;
        w_idx     = r_cnt + NB_W'(1);
        w_nsel    = r_n;
        w_lastsel = r_last;
        if (w_load) begin
            w_src     = i_msg_data;
            w_idx     = '0;
            w_nsel    = w_n;
            w_lastsel = w_last;
        end else begin
            w_src     = r_data;
            w_idx     = r_cnt + NB_W'(1);
        end
        w_beat     = f_beat(w_src, w_idx, w_nsel);
        w_beat_eop = (w_idx == w_lastsel);
        w_beat_len = w_beat_eop ? LEN_W'(int'(w_nsel) % BPB) : '0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Message latch, beat counter and registered packet outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_sop      <= 1'b0;
            r_eop      <= 1'b0;
            r_pkt_data <= '0;
            r_len      <= '0;
            r_data     <= '0;
            r_n        <= '0;
            r_last     <= '0;
            r_cnt      <= '0;
        end else begin
            // Ready only after a full cycle in IDLE, so it drops for two cycles around a packet.
            r_ready <= (r_state == IDLE) && (w_state_nxt == IDLE);
            r_busy  <= (w_state_nxt == SEND);
            if (w_load) begin
                r_data <= i_msg_data;
                r_n    <= w_n;
                r_last <= w_last;
            end
            if (w_load || (w_fire && !r_eop)) begin
                r_valid    <= 1'b1;
                r_sop      <= w_load;
                r_eop      <= w_beat_eop;
                r_pkt_data <= w_beat;
                r_len      <= w_beat_len;
                r_cnt      <= w_idx;
            end else if (w_fire) begin
                r_valid    <= 1'b0;
                r_sop      <= 1'b0;
                r_eop      <= 1'b0;
                r_pkt_data <= '0;
                r_len      <= '0;
            end
        end
    end

`ifdef ST_SER_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    // Counts dropped (zero-length) and clamped (oversize) messages, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_accept && (i_msg_nbytes == '0 || i_msg_nbytes > NB_W'(MAX_BYTES))
                     && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

    assign i_msg_ready = r_ready;
    assign o_pkt_valid = r_valid;
    assign o_pkt_sop   = r_sop;
    assign o_pkt_eop   = r_eop;
    assign o_pkt_data  = r_pkt_data;
    assign o_pkt_len   = r_len;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_st_msg_pkt_serializer.sv
// Directed bench for st_msg_pkt_serializer (WIDTH=32, MAX_BYTES=16).
module tb_st_msg_pkt_serializer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         msg_valid = 1'b0;
    logic         msg_ready;
    logic [127:0] msg_data = '0;
    logic [4:0]   msg_nbytes = '0;
    logic         pkt_valid, sop, eop, busy;
    logic         pkt_ready = 1'b0;
    logic [31:0]  pkt_data;
    logic [1:0]   pkt_len;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           err_exp = 0;
`ifdef ST_SER_ERR_CNT_EN
    logic [7:0]   err_cnt;
`endif

    always #5 clk = ~clk;

    st_msg_pkt_serializer #(.WIDTH(32), .MAX_BYTES(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_msg_valid(msg_valid), .i_msg_ready(msg_ready),
        .i_msg_data(msg_data), .i_msg_nbytes(msg_nbytes),
        .o_pkt_valid(pkt_valid), .o_pkt_ready(pkt_ready),
        .o_pkt_sop(sop), .o_pkt_eop(eop), .o_pkt_data(pkt_data),
        .o_pkt_len(pkt_len), .o_busy(busy)
`ifdef ST_SER_ERR_CNT_EN
        ,.o_err_cnt(err_cnt)
`endif
    );

    initial begin
        #200000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_msg(input logic [127:0] d, input logic [4:0] nb);
        int t;
        t = 0;
        while (msg_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_cmp++; if (msg_ready !== 1'b1) begin n_bad++; $display("FAIL send_ready: got %b exp 1", msg_ready); end
        msg_valid = 1'b1; msg_data = d; msg_nbytes = nb;
        @(negedge clk);
        msg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({pkt_valid, sop, eop, busy, msg_ready, pkt_len, pkt_data} !== 37'd0) begin n_bad++;
            $display("FAIL reset_outs: got %b%b%b%b%b %h %h exp all 0", pkt_valid, sop, eop, busy, msg_ready, pkt_len, pkt_data); end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (msg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_rise: got %b exp 1", msg_ready); end
        n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b exp 0", pkt_valid); end
    endtask

    task automatic test_single();
        pkt_ready = 1'b1;
        send_msg(128'h44332211, 5'd4);
        n_cmp++; if ({pkt_valid, sop, eop} !== 3'b111) begin n_bad++; $display("FAIL single_flags: got %b exp 111", {pkt_valid, sop, eop}); end
        n_cmp++; if (pkt_data !== 32'h11223344) begin n_bad++; $display("FAIL single_data: got %h exp 11223344", pkt_data); end
        n_cmp++; if (pkt_len !== 2'd0) begin n_bad++; $display("FAIL single_len: got %0d exp 0", pkt_len); end
        n_cmp++; if ({msg_ready, busy} !== 2'b01) begin n_bad++; $display("FAIL single_rdy_busy1: got %b exp 01", {msg_ready, busy}); end
        @(negedge clk);
        n_cmp++; if ({pkt_valid, msg_ready, busy} !== 3'b000) begin n_bad++; $display("FAIL single_after_eop: got %b exp 000", {pkt_valid, msg_ready, busy}); end
        @(negedge clk);
        n_cmp++; if (msg_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready_back: got %b exp 1", msg_ready); end
    endtask

    task automatic test_partial();
        logic [31:0] ed[2];
        logic [2:0]  ef[2];
        logic [1:0]  el[2];
        ed[0] = 32'h01020304; ef[0] = 3'b110; el[0] = 2'd0;
        ed[1] = 32'h05060700; ef[1] = 3'b101; el[1] = 2'd3;
        pkt_ready = 1'b1;
        send_msg(128'hFF07060504030201, 5'd7);
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (pkt_data !== ed[i]) begin n_bad++; $display("FAIL partial_data[%0d]: got %h exp %h", i, pkt_data, ed[i]); end
            n_cmp++; if ({pkt_valid, sop, eop} !== ef[i]) begin n_bad++; $display("FAIL partial_flags[%0d]: got %b exp %b", i, {pkt_valid, sop, eop}, ef[i]); end
            n_cmp++; if (pkt_len !== el[i]) begin n_bad++; $display("FAIL partial_len[%0d]: got %0d exp %0d", i, pkt_len, el[i]); end
            @(negedge clk);
        end
        n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL partial_end_valid: got %b exp 0", pkt_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ed[4];
        int          holds;
        ed[0] = 32'hA0A1A2A3; ed[1] = 32'hA4A5A6A7; ed[2] = 32'hA8A9AAAB; ed[3] = 32'hACADAEAF;
        pkt_ready = 1'b1;
        send_msg(128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 5'd16);
        for (int b = 0; b < 4; b++) begin
            holds = (b == 2) ? 4 : 1;
            for (int h = 0; h < holds; h++) begin
                n_cmp++; if (pkt_data !== ed[b]) begin n_bad++; $display("FAIL bp_data[%0d.%0d]: got %h exp %h", b, h, pkt_data, ed[b]); end
                n_cmp++; if ({pkt_valid, sop, eop} !== {1'b1, b == 0, b == 3}) begin n_bad++;
                    $display("FAIL bp_flags[%0d.%0d]: got %b exp %b", b, h, {pkt_valid, sop, eop}, {1'b1, b == 0, b == 3}); end
                n_cmp++; if (pkt_len !== 2'd0) begin n_bad++; $display("FAIL bp_len[%0d.%0d]: got %0d exp 0", b, h, pkt_len); end
                if (b == 2 && h == 0) pkt_ready = 1'b0;
                if (b == 2 && h == holds - 1) pkt_ready = 1'b1;
                @(negedge clk);
            end
        end
        n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL bp_end_valid: got %b exp 0", pkt_valid); end
    endtask

    task automatic test_zero();
        send_msg(128'hDEAD, 5'd0);
        err_exp++;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if ({pkt_valid, msg_ready, busy} !== 3'b010) begin n_bad++;
                $display("FAIL zero_state[%0d]: got %b exp 010", i, {pkt_valid, msg_ready, busy}); end
            @(negedge clk);
        end
`ifdef ST_SER_ERR_CNT_EN
        n_cmp++; if (err_cnt !== 8'(err_exp)) begin n_bad++; $display("FAIL zero_errcnt: got %0d exp %0d", err_cnt, err_exp); end
`endif
    endtask

    task automatic test_oversize();
        logic [31:0] ed[4];
        ed[0] = 32'h00010203; ed[1] = 32'h04050607; ed[2] = 32'h08090A0B; ed[3] = 32'h0C0D0E0F;
        pkt_ready = 1'b1;
        send_msg(128'h0F0E0D0C0B0A09080706050403020100, 5'd20);
        err_exp++;
        for (int b = 0; b < 4; b++) begin
            n_cmp++; if (pkt_data !== ed[b]) begin n_bad++; $display("FAIL over_data[%0d]: got %h exp %h", b, pkt_data, ed[b]); end
            n_cmp++; if ({pkt_valid, sop, eop, pkt_len} !== {1'b1, b == 0, b == 3, 2'd0}) begin n_bad++;
                $display("FAIL over_flags[%0d]: got %b exp %b", b, {pkt_valid, sop, eop, pkt_len}, {1'b1, b == 0, b == 3, 2'd0}); end
            @(negedge clk);
        end
        n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL over_end_valid: got %b exp 0", pkt_valid); end
`ifdef ST_SER_ERR_CNT_EN
        n_cmp++; if (err_cnt !== 8'(err_exp)) begin n_bad++; $display("FAIL over_errcnt: got %0d exp %0d", err_cnt, err_exp); end
`endif
    endtask

    task automatic test_reset_mid();
        pkt_ready = 1'b1;
        send_msg(128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0, 5'd16);
        @(negedge clk);
        n_cmp++; if ({pkt_valid, sop, eop, pkt_data} !== {3'b100, 32'hA4A5A6A7}) begin n_bad++;
            $display("FAIL rmid_beat1: got %b %h exp 100 a4a5a6a7", {pkt_valid, sop, eop}, pkt_data); end
        rst_n = 1'b0;
        err_exp = 0;
        #1;
        n_cmp++; if ({pkt_valid, sop, eop, busy, msg_ready, pkt_len, pkt_data} !== 37'd0) begin n_bad++;
            $display("FAIL rmid_async_clear: got %b%b%b%b%b %h %h exp all 0", pkt_valid, sop, eop, busy, msg_ready, pkt_len, pkt_data); end
`ifdef ST_SER_ERR_CNT_EN
        n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL rmid_errcnt: got %0d exp 0", err_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({msg_ready, pkt_valid} !== 2'b10) begin n_bad++; $display("FAIL rmid_ready: got %b exp 10", {msg_ready, pkt_valid}); end
        send_msg(128'h5554535251, 5'd5);
        n_cmp++; if ({pkt_valid, sop, eop, pkt_len, pkt_data} !== {3'b110, 2'd0, 32'h51525354}) begin n_bad++;
            $display("FAIL rmid_next_b0: got %b %0d %h exp 110 0 51525354", {pkt_valid, sop, eop}, pkt_len, pkt_data); end
        @(negedge clk);
        n_cmp++; if ({pkt_valid, sop, eop, pkt_len, pkt_data} !== {3'b101, 2'd1, 32'h55000000}) begin n_bad++;
            $display("FAIL rmid_next_b1: got %b %0d %h exp 101 1 55000000", {pkt_valid, sop, eop}, pkt_len, pkt_data); end
        @(negedge clk);
        n_cmp++; if (pkt_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_end_valid: got %b exp 0", pkt_valid); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_partial();
        test_backpressure();
        test_zero();
        test_oversize();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
